msrv32_alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the msrv32 execute stage: the base integer ALU plus the RV32M multiply/divide operations.
- Base ops complete in one registered cycle.
- M-extension ops use an iterative shift-add multiplier and a restoring divider behind a start/done handshake, so the pipeline stalls on busy_out.

---
 rtl/msrv32_alu_mc.sv | 218 +++++++++++++++++++++
 tb/tb_msrv32_alu_mc.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_alu_mc.sv
// msrv32 execute-stage ALU: base RV32I integer ops plus RV32M multiply/divide.
// Latency: base ops and divide fast paths 1 cycle; iterative MUL*/DIV*/REM* XLEN+1 cycles.
// Backpressure: start_in ignored while busy_out is high; a start in the done_out cycle is accepted.
//
// Ports: clk_in/rst_n_in (async active-low reset); start_in/mext_in/opcode_in/op_1_in/op_2_in
// form the request, sampled when start_in is seen with busy_out low; busy_out marks an
// iterative op in flight; done_out pulses for one cycle when result_out is updated.
// Optional macro ALU_FAST_MUL_EN: multiplies use a single-cycle combinational multiplier.
module msrv32_alu_mc #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            start_in,
    input  logic            mext_in,
    input  logic [3:0]      opcode_in,
    input  logic [XLEN-1:0] op_1_in,
    input  logic [XLEN-1:0] op_2_in,
    output logic            busy_out,
    output logic            done_out,
    output logic [XLEN-1:0] result_out
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic {IDLE, CALC} state_t;

    state_t              state_q, state_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]     a_q, a_d, b_q, b_d;          // operand magnitudes
    logic [XLEN-1:0]     quot_q, quot_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;                // product, or partial remainder in low bits
    logic [2:0]          op_q, op_d;
    logic                s1_q, s1_d, s2_q, s2_d;      // latched operand signs
    logic                done_q, done_d;
    logic [XLEN-1:0]     result_q, result_d;

    // ---------------- accept-time combinational values ----------------
    logic [XLEN-1:0]     base_res;
    logic [SHAMT_W-1:0]  shamt;
    logic                op1_signed, op2_signed, s1_in, s2_in;
    logic [XLEN-1:0]     mag1, mag2;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     div_fast_res;

    always_comb begin
        shamt = op_2_in[SHAMT_W-1:0];
        case (opcode_in)
            4'b0000: base_res = op_1_in + op_2_in;
            4'b1000: base_res = op_1_in - op_2_in;
            4'b0010: base_res = {{(XLEN-1){1'b0}}, (op_1_in < op_2_in)};
            4'b0011: base_res = {{(XLEN-1){1'b0}}, ($signed(op_1_in) < $signed(op_2_in))};
            4'b0111: base_res = op_1_in & op_2_in;
            4'b0110: base_res = op_1_in | op_2_in;
            4'b0100: base_res = op_1_in ^ op_2_in;
            4'b0001: base_res = op_1_in >> shamt;
            4'b0101: base_res = op_1_in << shamt;
            4'b1101: base_res = $unsigned($signed(op_1_in) >>> shamt);
            default: base_res = '0;
        endcase
    end

    always_comb begin
        // MUL/MULH/MULHSU: op_1 signed unless MULHU; op_2 signed for MUL/MULH only.
        // Divides: signed when opcode bit 0 is clear.
        if (opcode_in[2]) begin
            op1_signed = ~opcode_in[0];
            op2_signed = ~opcode_in[0];
        end else begin
            op1_signed = (opcode_in[1:0] != 2'b11);
            op2_signed = ~opcode_in[1];
        end
        s1_in    = op1_signed & op_1_in[XLEN-1];
        s2_in    = op2_signed & op_2_in[XLEN-1];
        mag1     = s1_in ? -op_1_in : op_1_in;
        mag2     = s2_in ? -op_2_in : op_2_in;
        div_zero = (op_2_in == '0);
        div_ovf  = ~opcode_in[0] && (op_1_in == MOST_NEG) && (op_2_in == '1);
        // Quotient ops have opcode bit 1 clear, remainder ops have it set.
        if (opcode_in[1])
            div_fast_res = div_zero ? op_1_in : '0;
        else
            div_fast_res = div_zero ? '1 : MOST_NEG;
    end

`ifdef ALU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_mul_res;

    always_comb begin
        // Sign-extend both operands to 2*XLEN; the low 2*XLEN product bits are exact.
        fast_prod    = {{XLEN{s1_in}}, op_1_in} * {{XLEN{s2_in}}, op_2_in};
        fast_mul_res = (opcode_in[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                 : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // ---------------- one iteration of the shift-add / restoring divide ----------------
    logic [2*XLEN-1:0] acc_step, addend;
    logic [XLEN-1:0]   quot_step;
    logic [XLEN:0]     trial, diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, final_res;

    always_comb begin
        trial     = {acc_q[XLEN-1:0], a_q[cnt_q]};
        diff      = trial - {1'b0, b_q};
        addend    = b_q[cnt_q] ? {{XLEN{1'b0}}, a_q} : '0;
        quot_step = quot_q;
        if (op_q[2]) begin
            // No borrow out of the trial subtraction means the divisor fits.
            quot_step = {quot_q[XLEN-2:0], ~diff[XLEN]};
            acc_step  = {{XLEN{1'b0}}, diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0]};
        end else begin
            // Multiplier bits consumed MSB first, so the partial product shifts left.
            acc_step  = {acc_q[2*XLEN-2:0], 1'b0} + addend;
        end

        prod_fix = (s1_q ^ s2_q) ? -acc_step : acc_step;
        q_fix    = (s1_q ^ s2_q) ? -quot_step : quot_step;
        r_fix    = s1_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        case (op_q)
            3'b000:         final_res = prod_fix[XLEN-1:0];
            3'b100, 3'b101: final_res = q_fix;
            3'b110, 3'b111: final_res = r_fix;
            default:        final_res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        quot_d   = quot_q;
        acc_d    = acc_q;
        op_d     = op_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    if (!mext_in) begin
                        result_d = base_res;
                        done_d   = 1'b1;
                    end else if (opcode_in[2] && (div_zero || div_ovf)) begin
                        result_d = div_fast_res;
                        done_d   = 1'b1;
`ifdef ALU_FAST_MUL_EN
                    end else if (!opcode_in[2]) begin
                        result_d = fast_mul_res;
                        done_d   = 1'b1;
`endif
                    end else begin
                        state_d = CALC;
                        cnt_d   = SHAMT_W'(XLEN-1);
                        a_d     = mag1;
                        b_d     = mag2;
                        s1_d    = s1_in;
                        s2_d    = s2_in;
                        op_d    = opcode_in[2:0];
                        acc_d   = '0;
                        quot_d  = '0;
                    end
                end
            end
            CALC: begin
                acc_d  = acc_step;
                quot_d = quot_step;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == '0) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    result_d = final_res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quot_q   <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            quot_q   <= quot_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy_out   = (state_q == CALC);
    assign done_out   = done_q;
    assign result_out = result_q;

endmodule

// File: tb/tb_msrv32_alu_mc.sv
module tb_msrv32_alu_mc;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        start_in;
    logic        mext_in;
    logic [3:0]  opcode_in;
    logic [31:0] op_1_in;
    logic [31:0] op_2_in;
    logic        busy_out;
    logic        done_out;
    logic [31:0] result_out;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        mext;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    msrv32_alu_mc #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .start_in   (start_in),
        .mext_in    (mext_in),
        .opcode_in  (opcode_in),
        .op_1_in    (op_1_in),
        .op_2_in    (op_2_in),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .result_out (result_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference: 64-bit arithmetic straight from the RISC-V definitions.
    function automatic logic [31:0] model(input logic mext, input logic [3:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        logic [63:0]        ua, ub, pu;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (!mext) begin
            case (op)
                4'b0000: return a + b;
                4'b1000: return a - b;
                4'b0010: return (a < b) ? 32'd1 : 32'd0;
                4'b0011: return (sa < sb) ? 32'd1 : 32'd0;
                4'b0111: return a & b;
                4'b0110: return a | b;
                4'b0100: return a ^ b;
                4'b0001: return a >> b[4:0];
                4'b0101: return a << b[4:0];
                4'b1101: begin p = sa >>> b[4:0]; return p[31:0]; end
                default: return 32'd0;
            endcase
        end
        case (op[2:0])
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                pu = ua / ub; return pu[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                pu = ua % ub; return pu[31:0];
            end
        endcase
    endfunction

    // Cycles from accept to done_out.
    function automatic int exp_lat(input logic mext, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        if (!mext) return 1;
        if (!op[2]) begin
`ifdef ALU_FAST_MUL_EN
            return 1;
`else
            return 33;
`endif
        end
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    // Issue one request in the current cycle and wait (bounded) for done_out.
    task automatic run_op(input logic mext, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output int lat,
                          output int busy_cnt, output logic busy_at_done);
        mext_in   = mext;
        opcode_in = op;
        op_1_in   = a;
        op_2_in   = b;
        start_in  = 1'b1;
        @(posedge clk_in); #1;
        start_in  = 1'b0;
        lat       = 1;
        busy_cnt  = 0;
        while (done_out !== 1'b1 && lat < 60) begin
            if (busy_out === 1'b1) busy_cnt++;
            @(posedge clk_in); #1;
            lat++;
        end
        res          = result_out;
        busy_at_done = busy_out;
    endtask

    task automatic test_reset();
        tests++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || result_out !== 32'h0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b result=%h, required 0/0/00000000",
                     busy_out, done_out, result_out);
        end
    endtask

    task automatic check_vectors(input string name, input vec_t v[]);
        logic [31:0] res;
        int          lat, bc, el;
        logic        bd;
        foreach (v[i]) begin
            el = exp_lat(v[i].mext, v[i].op, v[i].a, v[i].b);
            run_op(v[i].mext, v[i].op, v[i].a, v[i].b, res, lat, bc, bd);
            tests++;
            if (res !== v[i].exp) begin
                fails++;
                $display("FAIL %s[%0d] result: got %h, required %h", name, i, res, v[i].exp);
            end
            tests++;
            if (lat !== el || bc !== el - 1 || bd !== 1'b0) begin
                fails++;
                $display("FAIL %s[%0d] timing: latency %0d busy %0d busy@done %b, required %0d/%0d/0",
                         name, i, lat, bc, bd, el, el - 1);
            end
        end
    endtask

    task automatic test_base_directed();
        vec_t v[] = new[5];
        v[0] = '{1'b0, 4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE};
        v[1] = '{1'b0, 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000};
        v[2] = '{1'b0, 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd1};
        v[3] = '{1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0};
        v[4] = '{1'b0, 4'b1111, 32'd5, 32'd3, 32'd0};
        check_vectors("base", v);
    endtask

    task automatic test_mul_directed();
        vec_t v[] = new[3];
        v[0] = '{1'b1, 4'b0001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF};
        v[1] = '{1'b1, 4'b0000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA};
        v[2] = '{1'b1, 4'b1000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA};  // bit 3 ignored
        check_vectors("mul", v);
    endtask

    task automatic test_div_directed();
        vec_t v[] = new[8];
        v[0] = '{1'b1, 4'b0100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
        v[1] = '{1'b1, 4'b0110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
        v[2] = '{1'b1, 4'b0101, 32'd100, 32'd7, 32'd14};
        v[3] = '{1'b1, 4'b0111, 32'd100, 32'd7, 32'd2};
        v[4] = '{1'b1, 4'b0101, 32'd123, 32'd0, 32'hFFFF_FFFF};
        v[5] = '{1'b1, 4'b0110, 32'd123, 32'd0, 32'd123};
        v[6] = '{1'b1, 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[7] = '{1'b1, 4'b0110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        check_vectors("div", v);
    endtask

    task automatic test_random(input logic mext, input int n);
        vec_t v[] = new[n];
        foreach (v[i]) begin
            v[i].mext = mext;
            v[i].op   = 4'($urandom_range(0, 15));
            v[i].a    = pick();
            v[i].b    = pick();
            v[i].exp  = model(v[i].mext, v[i].op, v[i].a, v[i].b);
        end
        check_vectors(mext ? "rand_m" : "rand_base", v);
    endtask

    task automatic test_back_to_back();
        int lat;
        mext_in   = 1'b1;
        opcode_in = 4'b0100;
        op_1_in   = 32'hFFFF_FFF9;
        op_2_in   = 32'd2;
        start_in  = 1'b1;
        @(posedge clk_in); #1;
        // Keep requesting with different operands while the divide runs.
        opcode_in = 4'b0101;
        op_1_in   = 32'd1000;
        op_2_in   = 32'd3;
        lat = 1;
        while (done_out !== 1'b1 && lat < 60) begin
            @(posedge clk_in); #1;
            lat++;
        end
        tests++;
        if (lat !== 33 || result_out !== 32'hFFFF_FFFD) begin
            fails++;
            $display("FAIL hold_start: latency %0d result %h, required 33 fffffffd", lat, result_out);
        end
        mext_in   = 1'b0;
        opcode_in = 4'b0000;
        op_1_in   = 32'd1;
        op_2_in   = 32'd1;
        @(posedge clk_in); #1;
        start_in  = 1'b0;
        tests++;
        if (done_out !== 1'b1 || result_out !== 32'd2) begin
            fails++;
            $display("FAIL b2b_add: done %b result %h, required 1 00000002", done_out, result_out);
        end
        @(posedge clk_in); #1;
        tests++;
        if (done_out !== 1'b0 || result_out !== 32'd2) begin
            fails++;
            $display("FAIL done_pulse: done %b result %h, required 0 00000002", done_out, result_out);
        end
    endtask

    task automatic test_reset_mid();
        int          extra_done;
        logic [31:0] res;
        int          lat, bc;
        logic        bd;
        mext_in   = 1'b1;
        opcode_in = 4'b0101;
        op_1_in   = 32'd1000;
        op_2_in   = 32'd7;
        start_in  = 1'b1;
        @(posedge clk_in); #1;
        start_in  = 1'b0;
        repeat (9) begin @(posedge clk_in); #1; end
        tests++;
        if (busy_out !== 1'b1) begin
            fails++;
            $display("FAIL mid_busy: busy %b, required 1", busy_out);
        end
        rst_n_in = 1'b0;
        #1;
        tests++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || result_out !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset: busy=%b done=%b result=%h, required 0/0/00000000",
                     busy_out, done_out, result_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        extra_done = 0;
        repeat (40) begin
            @(posedge clk_in); #1;
            if (done_out === 1'b1 || busy_out === 1'b1) extra_done++;
        end
        tests++;
        if (extra_done !== 0) begin
            fails++;
            $display("FAIL abort: %0d cycles with done/busy after reset, required 0", extra_done);
        end
        run_op(1'b1, 4'b0101, 32'd100, 32'd7, res, lat, bc, bd);
        tests++;
        if (res !== 32'd14 || lat !== 33) begin
            fails++;
            $display("FAIL after_reset: result %h latency %0d, required 0000000e 33", res, lat);
        end
    endtask

    initial begin
        rst_n_in  = 1'b0;
        start_in  = 1'b0;
        mext_in   = 1'b0;
        opcode_in = 4'b0;
        op_1_in   = 32'h0;
        op_2_in   = 32'h0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        test_reset();
        test_base_directed();
        test_mul_directed();
        test_div_directed();
        test_random(1'b0, 40);
        test_random(1'b1, 40);
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
